// File: rtl/vtw_pin_compare.sv
// Multi-pin strobe comparator with vector counters, sticky pin flags,
// first-fail capture and a fail-log FIFO with optional halt-on-fail.
module vtw_pin_compare #(
  parameter int N_PINS     = 2,
  parameter int VEC_W      = 32,
  parameter int CNT_W      = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  halt_on_fail,
  input  logic                  strb_valid,
  input  logic [VEC_W-1:0]      strb_vector,
  input  logic [2*N_PINS-1:0]   strb_expect,
  input  logic [N_PINS-1:0]     pin_in,
  output logic                  busy,
  output logic                  halted,
  output logic [CNT_W-1:0]      compare_number,
  output logic [CNT_W-1:0]      fail_number,
  output logic [N_PINS-1:0]     pin_fail_sticky,
  output logic                  first_fail_valid,
  output logic [VEC_W-1:0]      first_fail_vector,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [VEC_W-1:0]      log_vector,
  output logic [N_PINS-1:0]     log_mask,
  output logic                  log_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic r_hof;

  logic [N_PINS-1:0] w_cmp_en;
  logic [N_PINS-1:0] w_mis;
  logic              w_acc;
  logic              w_any_cmp;
  logic              w_fail;

  logic w_go_start;
  logic w_go_stop;
  logic w_go_halt;

  logic [CNT_W-1:0]  r_cmp_cnt;
  logic [CNT_W-1:0]  r_fail_cnt;
  logic [N_PINS-1:0] r_sticky;
  logic              r_ff_valid;
  logic [VEC_W-1:0]  r_ff_vector;

  logic [VEC_W-1:0]  r_vec_mem  [FIFO_DEPTH];
  logic [N_PINS-1:0] r_mask_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_cnt;
  logic              r_ovf;

  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  // Codes 01/10 compare; 00/11 mask. Expected level is the code's MSB.
  always_comb begin
    w_cmp_en = '0;
    w_mis    = '0;
    for (int i = 0; i < N_PINS; i++) begin
      w_cmp_en[i] = strb_expect[2*i+1] ^ strb_expect[2*i];
      w_mis[i]    = w_cmp_en[i] &
                    (pin_in[i] != strb_expect[2*i+1]);
    end
  end

  assign w_acc     = (r_state == S_RUN) & strb_valid & ~start;
  assign w_any_cmp = |w_cmp_en;
  assign w_fail    = w_acc & (|w_mis);

  assign w_go_start = start;
  assign w_go_stop  = ~start & stop;
  assign w_go_halt  = ~start & ~stop & w_fail & r_hof;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (1'b1)
      w_go_start: w_state_nxt = S_RUN;
      w_go_stop:  w_state_nxt = S_IDLE;
      w_go_halt:  w_state_nxt = S_HALT;
      default:    w_state_nxt = r_state;
    endcase
  end

  always_comb begin
    busy   = (r_state == S_RUN);
    halted = (r_state == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)     r_hof <= 1'b0;
    else if (start) r_hof <= halt_on_fail;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      r_cmp_cnt  <= '0;
      r_fail_cnt <= '0;
    end else if (w_acc) begin
      if (w_any_cmp && (r_cmp_cnt != '1))
        r_cmp_cnt <= r_cmp_cnt + CNT_W'(1);
      if (w_fail && (r_fail_cnt != '1))
        r_fail_cnt <= r_fail_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      r_sticky    <= '0;
      r_ff_valid  <= 1'b0;
      r_ff_vector <= '0;
    end else if (w_fail) begin
      r_sticky <= r_sticky | w_mis;
      if (!r_ff_valid) begin
        r_ff_valid  <= 1'b1;
        r_ff_vector <= strb_vector;
      end
    end
  end

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = ~w_empty & log_ready;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts.
  assign w_push  = w_fail & (~w_full | w_pop);

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_vec_mem[r_wptr]  <= strb_vector;
      r_mask_mem[r_wptr] <= w_mis;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start)
      r_ovf <= 1'b0;
    else if (w_fail && w_full && !w_pop)
      r_ovf <= 1'b1;
  end

  assign compare_number    = r_cmp_cnt;
  assign fail_number       = r_fail_cnt;
  assign pin_fail_sticky   = r_sticky;
  assign first_fail_valid  = r_ff_valid;
  assign first_fail_vector = r_ff_vector;
  assign log_valid         = ~w_empty;
  assign log_vector        = w_empty ? '0 : r_vec_mem[r_rptr];
  assign log_mask          = w_empty ? '0 : r_mask_mem[r_rptr];
  assign log_overflow      = r_ovf;

endmodule

// File: tb/tb_vtw_pin_compare.sv
// Randomised and directed bench for vtw_pin_compare against a
// queue-based behavioural model.
module tb_vtw_pin_compare;

  localparam int NP    = 2;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        halt_on_fail;
  logic        strb_valid;
  logic [31:0] strb_vector;
  logic [3:0]  strb_expect;
  logic [1:0]  pin_in;
  logic        busy;
  logic        halted;
  logic [31:0] compare_number;
  logic [31:0] fail_number;
  logic [1:0]  pin_fail_sticky;
  logic        first_fail_valid;
  logic [31:0] first_fail_vector;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_vector;
  logic [1:0]  log_mask;
  logic        log_overflow;

  vtw_pin_compare #(
    .N_PINS(NP), .VEC_W(32), .CNT_W(32), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .halt_on_fail(halt_on_fail), .strb_valid(strb_valid),
    .strb_vector(strb_vector), .strb_expect(strb_expect),
    .pin_in(pin_in), .busy(busy), .halted(halted),
    .compare_number(compare_number), .fail_number(fail_number),
    .pin_fail_sticky(pin_fail_sticky),
    .first_fail_valid(first_fail_valid),
    .first_fail_vector(first_fail_vector),
    .log_valid(log_valid), .log_ready(log_ready),
    .log_vector(log_vector), .log_mask(log_mask),
    .log_overflow(log_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] v;
    logic [1:0]  m;
  } ent_t;

  bit          m_run, m_halt, m_hof, m_ffv, m_ovf;
  longint      m_cmp, m_fail;
  logic [1:0]  m_sticky;
  logic [31:0] m_ffvec;
  ent_t        q[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_clear();
    m_cmp = 0; m_fail = 0; m_sticky = '0;
    m_ffv = 0; m_ffvec = '0; m_ovf = 0;
    q.delete();
  endtask

  task automatic model_edge();
    bit         any_cmp, pop, acc;
    logic [1:0] mask;
    logic [1:0] code;
    if (!rst_n) begin
      m_clear();
      m_run = 0; m_halt = 0; m_hof = 0;
    end else if (start) begin
      m_clear();
      m_run = 1; m_halt = 0; m_hof = halt_on_fail;
    end else begin
      pop = (q.size() != 0) && log_ready;
      acc = m_run && strb_valid;
      any_cmp = 0;
      mask = '0;
      for (int i = 0; i < NP; i++) begin
        code = strb_expect[2*i +: 2];
        if (code == 2'b01 || code == 2'b10) begin
          any_cmp = 1;
          if (pin_in[i] != (code == 2'b10)) mask[i] = 1'b1;
        end
      end
      if (acc && any_cmp) m_cmp++;
      if (acc && mask != 0) begin
        m_fail++;
        m_sticky |= mask;
        if (!m_ffv) begin m_ffv = 1; m_ffvec = strb_vector; end
      end
      if (pop) void'(q.pop_front());
      if (acc && mask != 0) begin
        if (q.size() < DEPTH) q.push_back('{strb_vector, mask});
        else m_ovf = 1;
      end
      if (stop) begin
        m_run = 0; m_halt = 0;
      end else if (acc && mask != 0 && m_hof) begin
        m_run = 0; m_halt = 1;
      end
    end
  endtask

  task automatic check_all();
    chk("busy", busy, m_run);
    chk("halted", halted, m_halt);
    chk("cmp_num", compare_number, m_cmp);
    chk("fail_num", fail_number, m_fail);
    chk("sticky", pin_fail_sticky, m_sticky);
    chk("ff_valid", first_fail_valid, m_ffv);
    chk("ff_vec", first_fail_vector, m_ffvec);
    chk("log_valid", log_valid, q.size() != 0);
    chk("log_vec", log_vector, q.size() != 0 ? q[0].v : 32'd0);
    chk("log_mask", log_mask, q.size() != 0 ? q[0].m : 2'd0);
    chk("overflow", log_overflow, m_ovf);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic quiet();
    start = 0; stop = 0; strb_valid = 0; log_ready = 0;
  endtask

  task automatic strobe(input logic [31:0] v, input logic [3:0] e,
                        input logic [1:0] p);
    strb_valid = 1; strb_vector = v; strb_expect = e; pin_in = p;
    step();
  endtask

  task automatic do_start(input logic hof);
    start = 1; halt_on_fail = hof;
    step();
    start = 0;
  endtask

  initial begin
    logic [3:0] e;
    logic [1:0] p;
    int         pops;

    rst_n = 0; halt_on_fail = 0; strb_vector = '0;
    strb_expect = '0; pin_in = '0;
    quiet();
    step(); step();
    rst_n = 1;
    step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmp", compare_number, 32'd0);

    // four matching strobes
    do_start(1'b0);
    for (int k = 0; k < 4; k++) begin
      e = {($urandom_range(0, 1) ? 2'b10 : 2'b01),
           ($urandom_range(0, 1) ? 2'b10 : 2'b01)};
      p = {e[3], e[1]};
      strobe(32'(k + 1), e, p);
    end
    strb_valid = 0;
    chk("match_cmp", compare_number, 32'd4);
    chk("match_fail", fail_number, 32'd0);
    chk("match_logv", log_valid, 1'b0);

    strobe(32'd7, 4'b10_01, 2'b11);
    strb_valid = 0;
    chk("f7_fail", fail_number, 32'd1);
    chk("f7_sticky", pin_fail_sticky, 2'b01);
    chk("f7_ffvec", first_fail_vector, 32'd7);
    chk("f7_logvec", log_vector, 32'd7);
    chk("f7_logmask", log_mask, 2'b01);

    strobe(32'd8, 4'b00_11, 2'($urandom));
    strb_valid = 0;
    chk("mask_cmp", compare_number, 32'd5);
    chk("mask_fail", fail_number, 32'd1);

    // fill FIFO past capacity, then push with simultaneous pop
    do_start(1'b0);
    for (int k = 0; k < 9; k++) strobe(32'(100 + k), 4'b01_01, 2'b11);
    chk("ovf_set", log_overflow, 1'b1);
    log_ready = 1;
    strobe(32'd109, 4'b01_01, 2'b11);
    strb_valid = 0;
    chk("ovf_head", log_vector, 32'd101);
    pops = 0;
    for (int k = 0; k < 20 && log_valid; k++) begin
      pops++;
      step();
    end
    chk("drain_cnt", pops, 8);
    log_ready = 0;

    // halt-on-fail
    do_start(1'b1);
    strobe(32'd3, 4'b10_10, 2'b00);
    strobe(32'd4, 4'b10_10, 2'b00);
    strb_valid = 0;
    chk("halt_h", halted, 1'b1);
    chk("halt_fail", fail_number, 32'd1);
    chk("halt_log", log_vector, 32'd3);
    stop = 1; step(); stop = 0;

    // reset overrides start, strobes and pops
    do_start(1'b0);
    strobe(32'd5, 4'b01_10, 2'b01);
    rst_n = 0; start = 1; log_ready = 1;
    strobe(32'd6, 4'b01_10, 2'b01);
    rst_n = 1; start = 0; log_ready = 0; strb_valid = 0;
    chk("rst_ff", first_fail_valid, 1'b0);
    chk("rst_lv", log_valid, 1'b0);
    do_start(1'b0);
    strobe(32'd9, 4'b10_01, 2'b10);
    strb_valid = 0;
    chk("rst_recount", compare_number, 32'd1);

    for (int k = 0; k < 600; k++) begin
      rst_n        = ($urandom_range(0, 99) != 0);
      start        = ($urandom_range(0, 24) == 0);
      stop         = ($urandom_range(0, 29) == 0);
      halt_on_fail = 1'($urandom);
      strb_valid   = ($urandom_range(0, 9) < 7);
      strb_vector  = $urandom;
      strb_expect  = 4'($urandom);
      pin_in       = 2'($urandom);
      log_ready    = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
